instr_fetch_unit: RTL

//  Fetch stage directly upstream of the byte-addressed instruction memory.

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_if.sv | 46 ++++
 rtl/instr_fetch_unit_fetch_queue.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 89 ++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

    localparam int              XLEN             = 32;
    localparam int              INSTR_BYTES      = 4;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // True when an address cannot be fetched: misaligned, or the word would
    // extend past the end of instruction memory.
    function automatic logic fetch_addr_bad(input logic [XLEN-1:0] addr,
                                            input logic [XLEN-1:0] mem_bytes);
        return (addr > (mem_bytes - XLEN'(INSTR_BYTES))) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory, redirect and decoder-side signals of the fetch stage.
// master = fetch unit, slave = memory/decoder/branch side.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;
    logic            fetch_fault;
    logic [XLEN-1:0] fault_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output fetch_fault,
        output fault_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  fetch_fault,
        input  fault_pc
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry FIFO of {pc, instr} pairs. Entry 0 is always the head and is a
// register, so the decoder sees a clean flop output. Flush beats push/pop.
module instr_fetch_unit_fetch_queue
    import instr_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    fetch_entry_t r_entry [2];
    logic [1:0]   r_count;

    // Storage and occupancy update; the caller never pushes into a full
    // queue without popping in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= 2'd0;
            r_entry[0] <= '0;
            r_entry[1] <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_entry[0] <= i_data;
                        r_count    <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_entry[1] <= i_data;
                        r_count    <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_count != 2'd0) begin
                        r_entry[0] <= r_entry[1];
                        r_count    <= r_count - 2'd1;
                    end
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_entry[0] <= r_entry[1];
                        r_entry[1] <= i_data;
                    end else begin
                        r_entry[0] <= i_data;
                        r_count    <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_entry[0];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address, queues
// fetched instructions for the decoder, handles redirects and address faults.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] IMEM_BYTES = 32'd256
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  fetch_bus
);

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_fetch_fault;
    logic [XLEN-1:0] r_fault_pc;

    logic            w_q_valid;
    logic [1:0]      w_q_count;
    fetch_entry_t    w_q_head;
    fetch_entry_t    w_entry;
    logic            w_pop;
    logic            w_slot;
    logic            w_addr_bad;
    logic            w_push;
    logic            w_fault_hit;

    assign fetch_bus.imem_addr = r_fetch_pc;

    // A fetch slot exists when not halted, not redirecting and the queue has
    // room (counting the entry leaving this cycle). A bad address turns the
    // slot into a fault instead of a push.
    assign w_pop       = w_q_valid & fetch_bus.out_ready;
    assign w_slot      = !r_fetch_fault && !fetch_bus.redirect_valid &&
                         ((w_q_count != 2'd2) || w_pop);
    assign w_addr_bad  = fetch_addr_bad(r_fetch_pc, IMEM_BYTES);
    assign w_push      = w_slot & !w_addr_bad;
    assign w_fault_hit = w_slot &  w_addr_bad;

    assign w_entry.pc    = r_fetch_pc;
    assign w_entry.instr = fetch_bus.imem_rdata;

    instr_fetch_unit_fetch_queue u_fetch_queue (
        .clk     (clk),
        .reset   (reset),
        .i_flush (fetch_bus.redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop & !fetch_bus.redirect_valid),
        .i_data  (w_entry),
        .o_head  (w_q_head),
        .o_valid (w_q_valid),
        .o_count (w_q_count)
    );

    // PC and sticky fault state; a redirect wins over fetch and clears the
    // fault, and a bad target is only detected on the following fetch slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_fetch_fault <= 1'b0;
            r_fault_pc    <= '0;
        end else if (fetch_bus.redirect_valid) begin
            r_fetch_pc    <= fetch_bus.redirect_target;
            r_fetch_fault <= 1'b0;
        end else if (w_push) begin
            r_fetch_pc    <= r_fetch_pc + XLEN'(INSTR_BYTES);
        end else if (w_fault_hit) begin
            r_fetch_fault <= 1'b1;
            r_fault_pc    <= r_fetch_pc;
        end
    end

    // Head outputs read as zero whenever the queue is empty.
    always_comb begin
        fetch_bus.out_valid    = w_q_valid;
        fetch_bus.out_instr    = '0;
        fetch_bus.out_pc       = '0;
        fetch_bus.out_pc_plus4 = '0;
        if (w_q_valid) begin
            fetch_bus.out_instr    = w_q_head.instr;
            fetch_bus.out_pc       = w_q_head.pc;
            fetch_bus.out_pc_plus4 = w_q_head.pc + XLEN'(INSTR_BYTES);
        end
    end

    assign fetch_bus.fetch_fault = r_fetch_fault;
    assign fetch_bus.fault_pc    = r_fault_pc;

endmodule
